// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control sequencer: owns the IR, steps FETCH/DECODE/EXEC/MEM/WB, runs the memory handshakes and traps.
// Define MC_CSR_EN to accept SYSTEM/CSRRW and drive csr_we; otherwise SYSTEM is illegal.
module mc_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      inst,
    output logic [31:0]      ir,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             br_taken,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             csr_we,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    // Watchdog counter only needs to reach TIMEOUT-1.
    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LIM = WC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          cur;
    state_t          nxt;
    logic [WC_W-1:0] wcnt;
    logic [4:0]      op;
    logic            is_load, is_store, is_branch, is_jal, is_jalr, is_csr;
    logic            legal, sel_a, sel_b, wd_hit;
    logic            load_ir, retire, wc_inc;
    logic [1:0]      cause_n;

    assign op        = ir[6:2];
    assign is_load   = (op == OP_LOAD);
    assign is_store  = (op == OP_STORE);
    assign is_branch = (op == OP_BRANCH);
    assign is_jal    = (op == OP_JAL);
    assign is_jalr   = (op == OP_JALR);

`ifdef MC_CSR_EN
    localparam logic [4:0] OP_SYSTEM = 5'b11100;
    assign is_csr = (op == OP_SYSTEM) && (ir[14:12] == 3'b001);
`else
    assign is_csr = 1'b0;
`endif

    assign legal = (ir[1:0] == 2'b11) &&
                   (is_load || is_store || is_branch || is_jal || is_jalr || is_csr ||
                    op == OP_I || op == OP_R || op == OP_LUI || op == OP_AUIPC);

    assign sel_a  = (op == OP_AUIPC) || is_jal || is_branch;
    assign sel_b  = (op != OP_R) && !is_csr;
    assign wd_hit = (TIMEOUT != 0) && (wcnt == WC_LIM);
    assign state  = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= BOOT;
            ir         <= '0;
            instret    <= '0;
            halted     <= 1'b0;
            trap_cause <= 2'd0;
            wcnt       <= '0;
        end else begin
            cur <= nxt;
            if (load_ir) ir <= inst;
            if (retire) instret <= instret + CNT_W'(1);
            if (nxt == TRAP && cur != TRAP) begin
                halted     <= 1'b1;
                trap_cause <= cause_n;
            end
            // Any state change restarts the wait count, so FETCH and MEM always begin at zero.
            if (nxt != cur) wcnt <= '0;
            else if (wc_inc) wcnt <= wcnt + WC_W'(1);
        end
    end

    always_comb begin
        nxt       = cur;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        csr_we    = 1'b0;
        load_ir   = 1'b0;
        retire    = 1'b0;
        wc_inc    = 1'b0;
        cause_n   = 2'd0;
        case (cur)
            BOOT: nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    load_ir = 1'b1;
                    nxt     = DECODE;
                end else if (wd_hit) begin
                    nxt     = TRAP;
                    cause_n = 2'd2;
                end else begin
                    wc_inc = 1'b1;
                end
            end
            DECODE: begin
                if (!legal) begin
                    nxt     = TRAP;
                    cause_n = 2'd1;
                end else begin
                    nxt = EXEC;
                end
            end
            EXEC: begin
                alu_a_sel = sel_a;
                alu_b_sel = sel_b;
                if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = {1'b0, br_taken};
                    retire = 1'b1;
                    nxt    = FETCH;
                end else if (is_load || is_store) begin
                    nxt = MEM;
                end else begin
                    nxt = WB;
                end
            end
            MEM: begin
                alu_a_sel = sel_a;
                alu_b_sel = sel_b;
                dmem_req  = 1'b1;
                dmem_we   = is_store;
                if (dmem_ack) begin
                    if (is_store) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                        nxt    = FETCH;
                    end else begin
                        nxt = WB;
                    end
                end else if (wd_hit) begin
                    nxt     = TRAP;
                    cause_n = 2'd3;
                end else begin
                    wc_inc = 1'b1;
                end
            end
            WB: begin
                alu_a_sel = sel_a;
                alu_b_sel = sel_b;
                rf_we     = (ir[11:7] != 5'd0);
                csr_we    = is_csr;
                pc_we     = 1'b1;
                retire    = 1'b1;
                nxt       = FETCH;
                if (is_load) wb_sel = 2'd1;
                else if (is_jal || is_jalr) wb_sel = 2'd2;
                else if (is_csr) wb_sel = 2'd3;
                if (is_jal) pc_sel = 2'd1;
                else if (is_jalr) pc_sel = 2'd2;
            end
            TRAP: nxt = TRAP;
            default: nxt = BOOT;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: a per-instruction expectation model feeds a queue checked every cycle.
// Build with or without MC_CSR_EN; the CSRRW vector expects legal or illegal accordingly.
module tb_mc_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;
    localparam logic [2:0] S_BOOT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_ack = 1'b0;
    logic [31:0]   inst = '0;
    logic          dmem_ack = 1'b0;
    logic          br_taken = 1'b0;
    logic          imem_req, dmem_req, dmem_we, pc_we, alu_a_sel, alu_b_sel, rf_we, csr_we, halted;
    logic [1:0]    pc_sel, wb_sel, trap_cause;
    logic [31:0]   ir;
    logic [CW-1:0] instret;
    logic [2:0]    state;

    mc_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack), .inst(inst), .ir(ir),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .br_taken(br_taken),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .rf_we(rf_we), .wb_sel(wb_sel), .csr_we(csr_we), .halted(halted),
        .trap_cause(trap_cause), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    typedef enum int {C_ILL, C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_CSR} cls_t;

    typedef struct {
        logic [2:0]  st;
        logic        ireq, dreq, dwe, pcwe;
        logic [1:0]  pcsel;
        logic        care_alu, a, b, rfwe;
        logic [1:0]  wbsel;
        logic        csrwe, halted;
        logic [1:0]  cause;
        logic [31:0] icnt, ir;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cmp_e;
    logic [2:0]  st_log[$];
    int          ireq_cnt = 0, dreq_cnt = 0, csr_cnt = 0;
    int          n_cmp = 0, n_fail = 0;
    int          m_instret = 0;
    logic [31:0] m_ir = '0;
    logic        m_halted = 1'b0;
    logic [1:0]  m_cause = 2'd0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic cls_t classify(input logic [31:0] w);
        if (w[1:0] != 2'b11) return C_ILL;
        case (w[6:2])
            5'b01100: return C_R;
            5'b00100: return C_I;
            5'b00000: return C_LD;
            5'b01000: return C_ST;
            5'b11000: return C_BR;
            5'b11011: return C_JAL;
            5'b11001: return C_JALR;
            5'b01101: return C_LUI;
            5'b00101: return C_AUIPC;
`ifdef MC_CSR_EN
            5'b11100: return (w[14:12] == 3'b001) ? C_CSR : C_ILL;
`endif
            default: return C_ILL;
        endcase
    endfunction

    // {a_sel, b_sel} for each instruction class.
    function automatic logic [1:0] alu_ab(input cls_t c);
        case (c)
            C_I, C_LD, C_ST, C_JALR, C_LUI: return 2'b01;
            C_AUIPC, C_JAL, C_BR:           return 2'b11;
            default:                        return 2'b00;
        endcase
    endfunction

    function automatic exp_t base(input logic [2:0] st);
        exp_t e;
        e = '{st: st, ireq: 1'b0, dreq: 1'b0, dwe: 1'b0, pcwe: 1'b0, pcsel: 2'd0, care_alu: 1'b0,
              a: 1'b0, b: 1'b0, rfwe: 1'b0, wbsel: 2'd0, csrwe: 1'b0, halted: m_halted,
              cause: m_cause, icnt: 32'(m_instret), ir: m_ir};
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            st_log.push_back(state);
            ireq_cnt += int'(imem_req);
            dreq_cnt += int'(dmem_req);
            csr_cnt  += int'(csr_we);
            checkOutput("state", 32'(state), 32'(cmp_e.st));
            checkOutput("imem_req", 32'(imem_req), 32'(cmp_e.ireq));
            checkOutput("dmem_req", 32'(dmem_req), 32'(cmp_e.dreq));
            if (cmp_e.dreq) checkOutput("dmem_we", 32'(dmem_we), 32'(cmp_e.dwe));
            checkOutput("pc_we", 32'(pc_we), 32'(cmp_e.pcwe));
            if (cmp_e.pcwe) checkOutput("pc_sel", 32'(pc_sel), 32'(cmp_e.pcsel));
            if (cmp_e.care_alu) begin
                checkOutput("alu_a_sel", 32'(alu_a_sel), 32'(cmp_e.a));
                checkOutput("alu_b_sel", 32'(alu_b_sel), 32'(cmp_e.b));
            end
            checkOutput("rf_we", 32'(rf_we), 32'(cmp_e.rfwe));
            if (cmp_e.st == S_WB) checkOutput("wb_sel", 32'(wb_sel), 32'(cmp_e.wbsel));
            checkOutput("csr_we", 32'(csr_we), 32'(cmp_e.csrwe));
            checkOutput("halted", 32'(halted), 32'(cmp_e.halted));
            checkOutput("trap_cause", 32'(trap_cause), 32'(cmp_e.cause));
            checkOutput("instret", 32'(instret), cmp_e.icnt);
            checkOutput("ir", ir, cmp_e.ir);
        end
    end

    task automatic applyStimulus(input exp_t e, input logic ia, input logic [31:0] iw,
                                 input logic da, input logic bt);
        imem_ack = ia;
        inst     = iw;
        dmem_ack = da;
        br_taken = bt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic retire_model();
        m_instret = (m_instret + 1) % (1 << CW);
    endtask

    task automatic enter_trap(input logic [1:0] cause);
        m_halted = 1'b1;
        m_cause  = cause;
        for (int k = 0; k < 3; k++) applyStimulus(base(S_TRAP), 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        m_instret = 0;
        m_ir = '0;
        m_halted = 1'b0;
        m_cause = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_instret", 32'(instret), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_cause", 32'(trap_cause), 32'd0);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_ir", ir, 32'd0);
        st_log.delete();
        rst_n = 1'b1;
        applyStimulus(base(S_BOOT), 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    endtask

    // Result: 0 retired, 1 trapped, 2 aborted by reset in MEM.
    task automatic do_instr(input logic [31:0] word, input int iwait, input int dwait,
                            input logic br, input bit abort_mem, output int result);
        exp_t e;
        cls_t c;
        bit   got;
        result = 0;
        got = 1'b0;
        for (int k = 0; k < TO && !got; k++) begin
            e = base(S_FETCH);
            e.ireq = 1'b1;
            if (k == iwait) begin
                applyStimulus(e, 1'b1, word, 1'b0, 1'b0);
                got = 1'b1;
            end else begin
                applyStimulus(e, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
            end
        end
        if (!got) begin enter_trap(2'd2); result = 1; return; end
        m_ir = word;
        c = classify(word);
        applyStimulus(base(S_DECODE), 1'b1, word, 1'b1, br);
        if (c == C_ILL) begin enter_trap(2'd1); result = 1; return; end
        e = base(S_EXEC);
        e.care_alu = 1'b1;
        {e.a, e.b} = alu_ab(c);
        if (c == C_BR) begin
            e.pcwe = 1'b1;
            e.pcsel = {1'b0, br};
            applyStimulus(e, 1'b1, 32'hFFFF_FFFF, 1'b1, br);
            retire_model();
            return;
        end
        applyStimulus(e, 1'b1, 32'hFFFF_FFFF, 1'b1, br);
        if (c == C_LD || c == C_ST) begin
            got = 1'b0;
            for (int k = 0; k < TO && !got; k++) begin
                e = base(S_MEM);
                e.care_alu = 1'b1;
                {e.a, e.b} = alu_ab(c);
                e.dreq = 1'b1;
                e.dwe = (c == C_ST);
                if (abort_mem && k == 1) begin
                    imem_ack = 1'b0;
                    dmem_ack = 1'b0;
                    exp_q.push_back(e);
                    @(negedge clk);
                    #1;
                    rst_n = 1'b0;
                    #1;
                    checkOutput("abort_dmem_req", 32'(dmem_req), 32'd0);
                    checkOutput("abort_state", 32'(state), 32'd0);
                    checkOutput("abort_instret", 32'(instret), 32'd0);
                    result = 2;
                    return;
                end
                if (k == dwait) begin
                    if (c == C_ST) e.pcwe = 1'b1;
                    applyStimulus(e, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
                    got = 1'b1;
                end else begin
                    applyStimulus(e, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
                end
            end
            if (!got) begin enter_trap(2'd3); result = 1; return; end
            if (c == C_ST) begin retire_model(); return; end
        end
        e = base(S_WB);
        e.care_alu = 1'b1;
        {e.a, e.b} = alu_ab(c);
        e.rfwe  = (word[11:7] != 5'd0);
        e.csrwe = (c == C_CSR);
        e.pcwe  = 1'b1;
        e.wbsel = (c == C_LD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : (c == C_CSR) ? 2'd3 : 2'd0;
        e.pcsel = (c == C_JAL) ? 2'd1 : (c == C_JALR) ? 2'd2 : 2'd0;
        applyStimulus(e, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        retire_model();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int          r;
        logic [2:0]  addi_seq [5];
        logic [31:0] vec [8];
        addi_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
        vec = '{32'h0020A023, 32'h008000EF, 32'h00008067, 32'h123450B7,
                32'h00001117, 32'h002081B3, 32'h00A00113, 32'h00100013};

        apply_reset();
        do_instr(32'h00500093, 0, 0, 1'b0, 1'b0, r);
        checkOutput("addi_seq_len", 32'(st_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < st_log.size(); i++)
            checkOutput("addi_seq", 32'(st_log[i]), 32'(addi_seq[i]));
        checkOutput("addi_next_state", 32'(state), 32'd1);
        checkOutput("addi_instret", 32'(instret), 32'd1);

        st_log.delete();
        do_instr(32'h00208463, 0, 0, 1'b1, 1'b0, r);
        checkOutput("beq_cycles", 32'(st_log.size() + 1), 32'd4);
        checkOutput("beq_instret", 32'(instret), 32'd2);
        do_instr(32'h00208463, 1, 0, 1'b0, 1'b0, r);

        dreq_cnt = 0;
        do_instr(32'h0000A103, 0, 3, 1'b0, 1'b0, r);
        checkOutput("lw_dreq_cycles", 32'(dreq_cnt), 32'd4);
        checkOutput("lw_instret", 32'(instret), 32'd4);

        for (int i = 0; i < 6; i++) do_instr(vec[i], i % 3, 1, 1'b0, 1'b0, r);

        csr_cnt = 0;
        do_instr(32'h34011073, 0, 0, 1'b0, 1'b0, r);
`ifdef MC_CSR_EN
        checkOutput("csr_we_seen", 32'(csr_cnt), 32'd1);
        checkOutput("csr_instret", 32'(instret), 32'd11);
`else
        checkOutput("csr_illegal_cause", 32'(trap_cause), 32'd1);
        checkOutput("csr_we_seen", 32'(csr_cnt), 32'd0);
`endif

        apply_reset();
        ireq_cnt = 0;
        do_instr(32'h00500093, 99, 0, 1'b0, 1'b0, r);
        checkOutput("ito_fetch_cycles", 32'(ireq_cnt), 32'd4);
        checkOutput("ito_cause", 32'(trap_cause), 32'd2);
        checkOutput("ito_halted", 32'(halted), 32'd1);
        checkOutput("ito_imem_req", 32'(imem_req), 32'd0);

        apply_reset();
        do_instr(32'h00000000, 0, 0, 1'b0, 1'b0, r);
        checkOutput("ill_cause", 32'(trap_cause), 32'd1);

        apply_reset();
        do_instr(32'h0000A103, 0, 99, 1'b0, 1'b0, r);
        checkOutput("dto_cause", 32'(trap_cause), 32'd3);

        apply_reset();
        do_instr(32'h00500093, 0, 0, 1'b0, 1'b0, r);
        do_instr(32'h0020A023, 0, 5, 1'b0, 1'b1, r);
        checkOutput("abort_taken", 32'(r), 32'd2);

        apply_reset();
        for (int i = 0; i < 17; i++) do_instr(vec[6 + (i % 2)], 0, 0, 1'b0, 1'b0, r);
        checkOutput("wrap_instret", 32'(instret), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
